regfile_exec_ctrl: RTL and testbench
====================================

// Module: regfile_exec_ctrl
// PURPOSE
//  Multi-cycle execute/write-back controller that sits directly in front of the 8x16 register file.
//  Accepts one instruction word per handshake and drives the file's two read indices.
//  Samples the two read buses, computes an ALU or shift-add multiply result, and issues a
//  single-cycle write (we/c_index/d_input) back into the file. Status flags are reported per instruction.
// PARAMETERS
//  WIDTH     16  datapath width; must match the register-file word width
//  IDX_W     3   register index width (8 registers)
//  MUL_EN    1   1: opcode MUL is legal; 0: MUL is treated as illegal
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      asynchronous, active-high reset
//  instr        in   16     [15:12] op, [11:9] c, [8:6] a, [5:3] b, [2:0] imm3
//  instr_valid  in   1      instr is valid this cycle
//  instr_ready  out  1      controller can accept instr this cycle
//  a_index      out  IDX_W  register-file read port A select (registered)
//  b_index      out  IDX_W  register-file read port B select (registered)
//  a_data       in   WIDTH  register-file read port A data (combinational from a_index)
//  b_data       in   WIDTH  register-file read port B data
//  we           out  1      register-file write enable, one-cycle pulse
//  c_index      out  IDX_W  register-file write select
//  d_input      out  WIDTH  register-file write data
//  zero         out  1      last written result == 0
//  carry        out  1      carry/borrow out of the last ADD/SUB
//  illegal      out  1      one-cycle pulse: illegal opcode retired, no write
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs are 0, except instr_ready=1. Internal operand and result regs = 0.
//  Reset mid-instruction abandons the instruction. No write occurs.
//  Handshake: accept when instr_valid && instr_ready. instr_ready=1 only in IDLE, which gives one instruction in flight.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE; EXEC -> MUL (WIDTH cycles) -> WB; EXEC -> IDLE on illegal.
//  Cycle N accept: instr is latched, and a_index/b_index are registered to instr[8:6]/[5:3].
//  N+1 READ: the indices are stable, and the file settles.
//  N+2 EXEC: a_data/b_data are sampled into opA/opB. Single-cycle ops compute result.
//  N+3 WB: we=1, c_index=instr[11:9], d_input=result. zero/carry update here only.
//  N+4: IDLE, and instr_ready=1. The next accept is possible at N+4, so ALU throughput is 1 instruction per 4 cycles.
//  Opcodes (results truncated to WIDTH):
//   0 NOP: no write, returns to IDLE after EXEC, and flags are held.
//   1 ADD: a+b, carry = bit WIDTH.
//   2 SUB: a-b, carry = borrow (a<b unsigned).
//   3 AND.  4 OR.  5 XOR.
//   6 SHL: a << imm3.  7 SHR: logical a >> imm3. A shift of 0 passes a unchanged.
//   8 LDI: result = zero-extended instr[8:0]. The read data is ignored.
//   9 MUL: low WIDTH bits of a*b, unsigned shift-add over exactly WIDTH cycles in MUL, then WB.
//     MUL latency is accept -> we = 3+WIDTH cycles (19 for WIDTH=16). carry is cleared.
//   10-15 (and 9 if MUL_EN=0): illegal. The illegal pulse is issued in EXEC, with no write, and flags are held.
//  carry is cleared by every written op other than ADD/SUB.
//  c == a or c == b is legal. The operands are captured in EXEC, before the WB write.
//  The write lands at the end of the WB cycle. The next instruction reading the same register
//  sees the new value, because READ occurs at least 1 cycle later.
//  instr_valid while busy: no accept. instr must be held by the sender until accepted.
//  A simultaneous reset and instr_valid gives reset priority, and nothing is accepted.
//  Overflow wraps modulo 2^WIDTH. There are no exceptions.
// TESTING
//  Reset: assert reset mid-MUL -> outputs 0, instr_ready=1, and no we pulse follows.
//  LDI r1,5; LDI r2,3; ADD r3=r1+r2 -> we at N+3 with c=3, d=0x0008, zero=0, carry=0.
//  R1=0xFFFF, R2=1, ADD r4 -> d=0x0000, zero=1, carry=1. SUB r5=r2-r1 -> d=0x0002, carry=1.
//  R1=0x0123, R2=0x0100, MUL r6 -> we exactly 19 cycles after accept, d=0x2300 (truncated).
//  SHL r7=r1<<3 with r1=0x9001 -> 0x8008. SHR by 0 -> unchanged. ADD r1=r1+r1 with r1=2 -> r1=4.
//  op=0xF -> illegal pulse 1 cycle, and we stays 0. instr_valid held during busy -> exactly one accept.

Source files
------------

// File: rtl/regfile_exec_ctrl.sv
// Execute/write-back controller in front of an 8-entry register file.
// Fetches operands through registered read indices, runs ALU or shift-add MUL, writes back one word.
module regfile_exec_ctrl #(
  parameter int WIDTH  = 16,
  parameter int IDX_W  = 3,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [IDX_W-1:0] a_index,
  output logic [IDX_W-1:0] b_index,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             we,
  output logic [IDX_W-1:0] c_index,
  output logic [WIDTH-1:0] d_input,
  output logic             zero,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for an instruction, instr_ready high
  // S_READ | read indices stable, register file settling
  // S_EXEC | operands sampled; single-cycle result or illegal pulse
  // S_MUL  | one shift-add step per cycle, WIDTH cycles
  // S_WB   | we pulse with c_index/d_input
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [15:0]      instr_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] a_index_q;
  logic [IDX_W-1:0] b_index_q;
  logic [IDX_W-1:0] c_index_q;
  logic [WIDTH-1:0] d_input_q;
  logic             we_q;
  logic             zero_q;
  logic             carry_q;
  logic             illegal_q;

  logic [3:0]       op;
  logic             op_nop;
  logic             op_mul;
  logic             op_illegal;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] acc_d;

  assign op         = instr_q[15:12];
  assign op_nop     = (op == 4'd0);
  assign op_mul     = (op == 4'd9) && MUL_EN;
  assign op_illegal = (op >= 4'd10) || ((op == 4'd9) && !MUL_EN);

  always_comb begin
    sum       = {1'b0, a_data} + {1'b0, b_data};
    diff      = {1'b0, a_data} - {1'b0, b_data};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      4'd1: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      4'd2: begin
        // the extra top bit of the difference is the unsigned borrow
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      4'd3:    alu_res = a_data & b_data;
      4'd4:    alu_res = a_data | b_data;
      4'd5:    alu_res = a_data ^ b_data;
      4'd6:    alu_res = a_data << instr_q[2:0];
      4'd7:    alu_res = a_data >> instr_q[2:0];
      4'd8:    alu_res = WIDTH'(instr_q[8:0]);
      default: alu_res = '0;
    endcase
  end

  assign acc_d = acc_q + (opb_q[0] ? opa_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      a_index_q <= '0;
      b_index_q <= '0;
      c_index_q <= '0;
      d_input_q <= '0;
      we_q      <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q   <= instr;
            a_index_q <= IDX_W'(instr[8:6]);
            b_index_q <= IDX_W'(instr[5:3]);
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          illegal_q <= op_illegal;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          opa_q <= a_data;
          opb_q <= b_data;
          if (op_illegal || op_nop) begin
            state_q <= S_IDLE;
          end else if (op_mul) begin
            acc_q   <= '0;
            cnt_q   <= MUL_LAST;
            state_q <= S_MUL;
          end else begin
            we_q      <= 1'b1;
            c_index_q <= IDX_W'(instr_q[11:9]);
            d_input_q <= alu_res;
            zero_q    <= (alu_res == '0);
            carry_q   <= alu_carry;
            state_q   <= S_WB;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q - CNT_W'(1);
          // last step goes straight to the write-back registers
          if (cnt_q == '0) begin
            we_q      <= 1'b1;
            c_index_q <= IDX_W'(instr_q[11:9]);
            d_input_q <= acc_d;
            zero_q    <= (acc_d == '0);
            carry_q   <= 1'b0;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign a_index     = a_index_q;
  assign b_index     = b_index_q;
  assign c_index     = c_index_q;
  assign d_input     = d_input_q;
  assign we          = we_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Bench for regfile_exec_ctrl: attached 8x16 register file, directed vector table,
// hand-written multi-cycle sequences and random instructions against an arithmetic model.
module tb_regfile_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  a_index;
  logic [2:0]  b_index;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        we;
  logic [2:0]  c_index;
  logic [15:0] d_input;
  logic        zero;
  logic        carry;
  logic        illegal;
  logic        busy;

  always #5 clk = ~clk;

  regfile_exec_ctrl #(.WIDTH(16), .IDX_W(3), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .a_index(a_index), .b_index(b_index),
    .a_data(a_data), .b_data(b_data), .we(we), .c_index(c_index),
    .d_input(d_input), .zero(zero), .carry(carry), .illegal(illegal), .busy(busy)
  );

  // register file the controller drives
  logic [15:0] rf [8];
  logic        rf_clr;
  assign a_data = rf[a_index];
  assign b_data = rf[b_index];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
    end else if (we) begin
      rf[c_index] <= d_input;
    end
  end

  int acc_cnt = 0;
  int we_cnt  = 0;
  always @(posedge clk) if (!reset && instr_valid && instr_ready) acc_cnt++;
  always @(negedge clk) if (we) we_cnt++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // reference model: plain arithmetic over an array of register values
  int unsigned mrf [8];
  bit          m_zero;
  bit          m_carry;

  task automatic model_step(input logic [15:0] ins, output bit w, output bit ill,
                            output logic [15:0] d, output int lat);
    int unsigned op, a, b, sh, r;
    longint unsigned p;
    op = ins[15:12]; a = mrf[ins[8:6]]; b = mrf[ins[5:3]]; sh = ins[2:0];
    w = 1; ill = 0; lat = 3; r = 0;
    case (op)
      0: w = 0;
      1: begin r = (a + b) % 65536; m_carry = (a + b) > 65535; end
      2: begin r = (a + 65536 - b) % 65536; m_carry = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * (1 << sh)) % 65536;
      7: r = a / (1 << sh);
      8: r = ins[8:0];
      9: begin p = longint'(a) * longint'(b); r = int'(p % 65536); lat = 19; end
      default: begin w = 0; ill = 1; end
    endcase
    if (w) begin
      if (op != 1 && op != 2) m_carry = 0;
      m_zero = (r == 0);
      mrf[ins[11:9]] = r;
    end
    d = r[15:0];
  endtask

  function automatic logic [15:0] enc(input int op, input int c, input int a, input int b, input int imm);
    logic [3:0] o; logic [2:0] cc, aa, bb, ii;
    o = op[3:0]; cc = c[2:0]; aa = a[2:0]; bb = b[2:0]; ii = imm[2:0];
    return {o, cc, aa, bb, ii};
  endfunction

  function automatic logic [15:0] ldi(input int c, input int imm9);
    logic [2:0] cc; logic [8:0] v;
    cc = c[2:0]; v = imm9[8:0];
    return {4'd8, cc, v};
  endfunction

  // issue one instruction at a negedge and watch it retire
  task automatic run_instr(input logic [15:0] ins, input bit ew, input bit eill,
                           input logic [15:0] ed, input bit ez, input bit ec,
                           input int elat, input string tag);
    int wait_n, we_k, ill_k, rdy_k, we_n, ill_n;
    logic [2:0] got_ci;
    logic [15:0] got_d;
    logic got_z, got_cy;
    wait_n = 0; we_k = -1; ill_k = -1; rdy_k = -1; we_n = 0; ill_n = 0;
    got_ci = 0; got_d = 0; got_z = 0; got_cy = 0;
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    check({tag, ".accept"}, instr_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin instr_valid = 1'b0; instr = 16'($urandom); end
      if (we) begin
        if (we_n == 0) begin
          we_k = k; got_ci = c_index; got_d = d_input; got_z = zero; got_cy = carry;
        end
        we_n++;
      end
      if (illegal) begin ill_k = k; ill_n++; end
      if (instr_ready) begin rdy_k = k; break; end
    end
    check({tag, ".we_cnt"}, we_n, ew ? 1 : 0);
    check({tag, ".ill_cnt"}, ill_n, eill ? 1 : 0);
    check({tag, ".ready_at"}, rdy_k, ew ? elat + 1 : 3);
    if (ew) begin
      check({tag, ".lat"}, we_k, elat);
      check({tag, ".c_index"}, got_ci, ins[11:9]);
      check({tag, ".d"}, got_d, ed);
      check({tag, ".zero"}, got_z, ez);
      check({tag, ".carry"}, got_cy, ec);
    end else begin
      check({tag, ".zero_held"}, zero, ez);
      check({tag, ".carry_held"}, carry, ec);
    end
    if (eill) check({tag, ".ill_at"}, ill_k, 2);
  endtask

  typedef struct {
    logic [15:0] ins;
    bit          w;
    bit          ill;
    logic [15:0] d;
    bit          z;
    bit          c;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [15:0] ins, input bit w, input bit ill,
                         input logic [15:0] d, input bit z, input bit c, input int lat);
    vec_t v;
    v.ins = ins; v.w = w; v.ill = ill; v.d = d; v.z = z; v.c = c; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"},   instr_ready, 1);
    check({tag, ".busy"},    busy, 0);
    check({tag, ".we"},      we, 0);
    check({tag, ".illegal"}, illegal, 0);
    check({tag, ".a_index"}, a_index, 0);
    check({tag, ".b_index"}, b_index, 0);
    check({tag, ".c_index"}, c_index, 0);
    check({tag, ".d_input"}, d_input, 0);
    check({tag, ".zero"},    zero, 0);
    check({tag, ".carry"},   carry, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mw, mill;
    logic [15:0] md, rnd_ins;
    int mlat, acc0, we0;

    for (int i = 0; i < 8; i++) mrf[i] = 0;
    m_zero = 0; m_carry = 0;
    reset = 1'b1; rf_clr = 1'b1; instr_valid = 1'b0; instr = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0; rf_clr = 1'b0;

    add_vec(ldi(1, 5),             1, 0, 16'h0005, 0, 0, 3);
    add_vec(ldi(2, 3),             1, 0, 16'h0003, 0, 0, 3);
    add_vec(enc(1, 3, 1, 2, 0),    1, 0, 16'h0008, 0, 0, 3);
    add_vec(ldi(0, 0),             1, 0, 16'h0000, 1, 0, 3);
    add_vec(ldi(4, 1),             1, 0, 16'h0001, 0, 0, 3);
    add_vec(enc(2, 1, 0, 4, 0),    1, 0, 16'hFFFF, 0, 1, 3);
    add_vec(ldi(2, 1),             1, 0, 16'h0001, 0, 0, 3);
    add_vec(enc(1, 4, 1, 2, 0),    1, 0, 16'h0000, 1, 1, 3);
    add_vec(enc(2, 5, 2, 1, 0),    1, 0, 16'h0002, 0, 1, 3);
    add_vec(ldi(1, 'h123),         1, 0, 16'h0123, 0, 0, 3);
    add_vec(ldi(2, 'h100),         1, 0, 16'h0100, 0, 0, 3);
    add_vec(enc(9, 6, 1, 2, 0),    1, 0, 16'h2300, 0, 0, 19);
    add_vec(enc(15, 1, 2, 3, 4),   0, 1, 16'h0000, 0, 0, 3);
    add_vec(enc(0, 1, 2, 3, 0),    0, 0, 16'h0000, 0, 0, 3);
    add_vec(ldi(1, 'h120),         1, 0, 16'h0120, 0, 0, 3);
    add_vec(enc(6, 1, 1, 0, 7),    1, 0, 16'h9000, 0, 0, 3);
    add_vec(ldi(2, 1),             1, 0, 16'h0001, 0, 0, 3);
    add_vec(enc(4, 1, 1, 2, 0),    1, 0, 16'h9001, 0, 0, 3);
    add_vec(enc(6, 7, 1, 0, 3),    1, 0, 16'h8008, 0, 0, 3);
    add_vec(enc(7, 6, 7, 0, 0),    1, 0, 16'h8008, 0, 0, 3);
    add_vec(ldi(1, 2),             1, 0, 16'h0002, 0, 0, 3);
    add_vec(enc(1, 1, 1, 1, 0),    1, 0, 16'h0004, 0, 0, 3);
    add_vec(enc(3, 5, 7, 1, 0),    1, 0, 16'h0000, 1, 0, 3);
    add_vec(enc(5, 3, 7, 1, 0),    1, 0, 16'h800C, 0, 0, 3);
    add_vec(enc(7, 2, 7, 0, 3),    1, 0, 16'h1001, 0, 0, 3);

    foreach (vecs[i]) begin
      model_step(vecs[i].ins, mw, mill, md, mlat);
      if (vecs[i].w)
        run_instr(vecs[i].ins, vecs[i].w, vecs[i].ill, vecs[i].d, vecs[i].z, vecs[i].c,
                  vecs[i].lat, $sformatf("vec%0d", i));
      else
        run_instr(vecs[i].ins, vecs[i].w, vecs[i].ill, vecs[i].d, m_zero, m_carry,
                  vecs[i].lat, $sformatf("vec%0d", i));
    end

    // instr_valid held through the whole busy period: one accept, one write
    acc0 = acc_cnt; we0 = we_cnt;
    instr = ldi(3, 'h55); instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("hold.accepts", acc_cnt - acc0, 1);
    check("hold.writes", we_cnt - we0, 1);
    model_step(ldi(3, 'h55), mw, mill, md, mlat);
    check("hold.rf3", rf[3], 16'h0055);

    // reset in the middle of a multiply, with instr_valid asserted alongside
    instr = enc(9, 6, 1, 2, 0); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("midmul.busy", busy, 1);
    acc0 = acc_cnt; we0 = we_cnt;
    reset = 1'b1; instr = ldi(5, 7); instr_valid = 1'b1;
    #1;
    check_reset_outputs("midmul");
    @(negedge clk);
    instr_valid = 1'b0; reset = 1'b0;
    check("midmul.no_accept", acc_cnt - acc0, 0);
    repeat (25) @(negedge clk);
    check("midmul.no_we", we_cnt - we0, 0);
    check("midmul.idle", instr_ready, 1);
    m_zero = 0; m_carry = 0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) rnd_ins = ldi($urandom_range(0, 7), $urandom_range(0, 511));
      else rnd_ins = enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
      model_step(rnd_ins, mw, mill, md, mlat);
      run_instr(rnd_ins, mw, mill, md, m_zero, m_carry, mlat, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
